hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_stage_reg.sv | 56 +++++
 rtl/hazard_ctrl.sv | 79 +++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding source codes, the "operand not read" Tuse marker and
// the pipeline stage record shared by the hazard controller and its stage registers.
package hazard_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int T_W_DEF    = 3;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [T_W_DEF-1:0] TUSE_NONE = 3'd7;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] raddr0;
        logic [ADDR_W_DEF-1:0] raddr1;
        logic [ADDR_W_DEF-1:0] waddr;
        logic [T_W_DEF-1:0]    tnew;
    } stage_t;

endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one pipeline stage record {raddr0, raddr1, waddr, tnew}
// with bubble load and optional saturating (or forced-zero) tnew on load.
module hazard_stage_reg
    import hazard_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int T_W       = T_W_DEF,
    parameter bit DEC       = 1'b0,
    parameter bit ZERO_TNEW = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble,
    input  logic [ADDR_W-1:0] raddr0_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [T_W-1:0]    tnew_i,
    output logic [ADDR_W-1:0] raddr0_o,
    output logic [ADDR_W-1:0] raddr1_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [T_W-1:0]    tnew_o
);

    logic [ADDR_W-1:0] raddr0_d, raddr0_q;
    logic [ADDR_W-1:0] raddr1_d, raddr1_q;
    logic [ADDR_W-1:0] waddr_d, waddr_q;
    logic [T_W-1:0]    tnew_d, tnew_q;

    always_comb begin
        raddr0_d = bubble ? '0 : raddr0_i;
        raddr1_d = bubble ? '0 : raddr1_i;
        waddr_d  = bubble ? '0 : waddr_i;
        tnew_d   = (bubble || ZERO_TNEW) ? '0 :
                   (DEC && tnew_i != '0) ? tnew_i - T_W'(1) : tnew_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr0_q <= '0;
            raddr1_q <= '0;
            waddr_q  <= '0;
            tnew_q   <= '0;
        end else begin
            raddr0_q <= raddr0_d;
            raddr1_q <= raddr1_d;
            waddr_q  <= waddr_d;
            tnew_q   <= tnew_d;
        end
    end

    assign raddr0_o = raddr0_q;
    assign raddr1_o = raddr1_q;
    assign waddr_o  = waddr_q;
    assign tnew_o   = tnew_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Tuse/Tnew stall and forwarding control for a 5-stage pipeline,
// tracking the E, M and W instruction records.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int T_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] d_raddr0,
    input  logic [ADDR_W-1:0] d_raddr1,
    input  logic [T_W-1:0]    d_tuse0,
    input  logic [T_W-1:0]    d_tuse1,
    input  logic [ADDR_W-1:0] d_waddr,
    input  logic [T_W-1:0]    d_tnew,
    output logic              stall,
    output logic [1:0]        fwd_d0,
    output logic [1:0]        fwd_d1,
    output logic [1:0]        fwd_e0,
    output logic [1:0]        fwd_e1,
    output logic              fwd_m1
);

    logic [ADDR_W-1:0] e_raddr0, e_raddr1, e_waddr;
    logic [ADDR_W-1:0] m_raddr0, m_raddr1, m_waddr;
    logic [ADDR_W-1:0] w_raddr0, w_raddr1, w_waddr;
    logic [T_W-1:0]    e_tnew, m_tnew, w_tnew;

    hazard_stage_reg #(.ADDR_W(ADDR_W), .T_W(T_W), .DEC(1'b0), .ZERO_TNEW(1'b0)) u_e (
        .clk(clk), .rst_n(rst_n), .bubble(stall),
        .raddr0_i(d_raddr0), .raddr1_i(d_raddr1), .waddr_i(d_waddr), .tnew_i(d_tnew),
        .raddr0_o(e_raddr0), .raddr1_o(e_raddr1), .waddr_o(e_waddr), .tnew_o(e_tnew)
    );

    hazard_stage_reg #(.ADDR_W(ADDR_W), .T_W(T_W), .DEC(1'b1), .ZERO_TNEW(1'b0)) u_m (
        .clk(clk), .rst_n(rst_n), .bubble(1'b0),
        .raddr0_i(e_raddr0), .raddr1_i(e_raddr1), .waddr_i(e_waddr), .tnew_i(e_tnew),
        .raddr0_o(m_raddr0), .raddr1_o(m_raddr1), .waddr_o(m_waddr), .tnew_o(m_tnew)
    );

    hazard_stage_reg #(.ADDR_W(ADDR_W), .T_W(T_W), .DEC(1'b1), .ZERO_TNEW(1'b1)) u_w (
        .clk(clk), .rst_n(rst_n), .bubble(1'b0),
        .raddr0_i(m_raddr0), .raddr1_i(m_raddr1), .waddr_i(m_waddr), .tnew_i(m_tnew),
        .raddr0_o(w_raddr0), .raddr1_o(w_raddr1), .waddr_o(w_waddr), .tnew_o(w_tnew)
    );

    // A producer blocks a reader only while its result arrives later than the reader needs it.
    function automatic logic hazard(input logic [ADDR_W-1:0] ra, input logic [T_W-1:0] tu,
                                    input logic [ADDR_W-1:0] ew, input logic [T_W-1:0] et,
                                    input logic [ADDR_W-1:0] mw, input logic [T_W-1:0] mt);
        return ra != '0 && ((ew == ra && et > tu) || (mw == ra && mt > tu));
    endfunction

    // The youngest matching stage decides; if its value is not ready yet, fall back to RF.
    function automatic logic [1:0] pick(input logic [ADDR_W-1:0] ra, input logic use_e,
                                        input logic [ADDR_W-1:0] ew, input logic [T_W-1:0] et,
                                        input logic [ADDR_W-1:0] mw, input logic [T_W-1:0] mt,
                                        input logic [ADDR_W-1:0] ww, input logic [T_W-1:0] wt);
        return ra == '0                ? FWD_RF :
               (use_e && ew == ra)     ? (et == '0 ? FWD_E : FWD_RF) :
               mw == ra                ? (mt == '0 ? FWD_M : FWD_RF) :
               ww == ra                ? (wt == '0 ? FWD_W : FWD_RF) : FWD_RF;
    endfunction

    always_comb begin
        stall  = hazard(d_raddr0, d_tuse0, e_waddr, e_tnew, m_waddr, m_tnew) ||
                 hazard(d_raddr1, d_tuse1, e_waddr, e_tnew, m_waddr, m_tnew);
        fwd_d0 = pick(d_raddr0, 1'b1, e_waddr, e_tnew, m_waddr, m_tnew, w_waddr, w_tnew);
        fwd_d1 = pick(d_raddr1, 1'b1, e_waddr, e_tnew, m_waddr, m_tnew, w_waddr, w_tnew);
        fwd_e0 = pick(e_raddr0, 1'b0, e_waddr, e_tnew, m_waddr, m_tnew, w_waddr, w_tnew);
        fwd_e1 = pick(e_raddr1, 1'b0, e_waddr, e_tnew, m_waddr, m_tnew, w_waddr, w_tnew);
        fwd_m1 = m_raddr1 != '0 && w_waddr == m_raddr1;
    end

    logic unused_ok;
    assign unused_ok = ^{w_raddr0, w_raddr1};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed MIPS hazard scenarios plus random traffic, checked
// against an instruction-level pipeline model (tnew derived from stage age).
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] d_raddr0 = '0, d_raddr1 = '0, d_waddr = '0;
    logic [TW-1:0] d_tuse0 = '0, d_tuse1 = '0, d_tnew = '0;
    logic stall, fwd_m1;
    logic [1:0] fwd_d0, fwd_d1, fwd_e0, fwd_e1;

    int errors = 0;
    int checks = 0;

    typedef struct {int r0; int r1; int w; int t;} ins_t;
    ins_t pipe[3];

    always #5 clk = ~clk;

    hazard_ctrl #(.ADDR_W(AW), .T_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_raddr0(d_raddr0), .d_raddr1(d_raddr1),
        .d_tuse0(d_tuse0), .d_tuse1(d_tuse1),
        .d_waddr(d_waddr), .d_tnew(d_tnew),
        .stall(stall),
        .fwd_d0(fwd_d0), .fwd_d1(fwd_d1),
        .fwd_e0(fwd_e0), .fwd_e1(fwd_e1),
        .fwd_m1(fwd_m1)
    );

    // Remaining cycles until forwardable: entry tnew minus stages travelled, W always ready.
    function automatic int tn(int k);
        if (k == 2) return 0;
        return pipe[k].t > k ? pipe[k].t - k : 0;
    endfunction

    function automatic int m_stall();
        for (int i = 0; i < 2; i++) begin
            int ra = i ? int'(d_raddr1) : int'(d_raddr0);
            int tu = i ? int'(d_tuse1) : int'(d_tuse0);
            if (ra != 0)
                for (int k = 0; k < 2; k++)
                    if (pipe[k].w == ra && tn(k) > tu) return 1;
        end
        return 0;
    endfunction

    function automatic int m_fwd(int ra, int first);
        if (ra == 0) return 0;
        for (int k = first; k < 3; k++)
            if (pipe[k].w == ra) return tn(k) == 0 ? k + 1 : 0;
        return 0;
    endfunction

    function automatic int m_fwd_m1();
        return (pipe[1].r1 != 0 && pipe[2].w == pipe[1].r1) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/stall"}, {31'd0, stall}, m_stall());
        check({tag, "/fwd_d0"}, {30'd0, fwd_d0}, m_fwd(int'(d_raddr0), 0));
        check({tag, "/fwd_d1"}, {30'd0, fwd_d1}, m_fwd(int'(d_raddr1), 0));
        check({tag, "/fwd_e0"}, {30'd0, fwd_e0}, m_fwd(pipe[0].r0, 1));
        check({tag, "/fwd_e1"}, {30'd0, fwd_e1}, m_fwd(pipe[0].r1, 1));
        check({tag, "/fwd_m1"}, {31'd0, fwd_m1}, m_fwd_m1());
    endtask

    task automatic drive(input int r0, input int r1, input int tu0, input int tu1,
                         input int w, input int t);
        d_raddr0 = AW'(r0);
        d_raddr1 = AW'(r1);
        d_tuse0  = TW'(tu0);
        d_tuse1  = TW'(tu1);
        d_waddr  = AW'(w);
        d_tnew   = TW'(t);
        #2;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
    endtask

    task automatic step();
        int s;
        @(posedge clk);
        s = m_stall();
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = s ? '{0, 0, 0, 0} : '{int'(d_raddr0), int'(d_raddr1), int'(d_waddr), int'(d_tnew)};
        #1;
    endtask

    task automatic flush();
        drive(0, 0, 7, 7, 0, 0);
        repeat (3) step();
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        clear_model();
        check_all(tag);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        clear_model();
        #2;
        check_all("reset");
        check("reset_stall", {31'd0, stall}, 0);
        #6;
        rst_n = 1'b1;
        step();

        // lw $8 (tnew 2) then beq $8 (tuse 0): two stall cycles, then W forwards
        drive(0, 0, 7, 7, 8, 2);
        step();
        drive(8, 0, 0, 7, 0, 0);
        check("lw_beq_c1_stall", {31'd0, stall}, 1);
        check_all("lw_beq_c1");
        step();
        check("lw_beq_c2_stall", {31'd0, stall}, 1);
        step();
        check("lw_beq_c3_stall", {31'd0, stall}, 0);
        check("lw_beq_c3_fwd", {30'd0, fwd_d0}, 3);
        check_all("lw_beq_c3");
        flush();

        // addu $3 (tnew 1) then addu rs=$3 (tuse 1)
        drive(0, 0, 7, 7, 3, 1);
        step();
        drive(3, 0, 1, 7, 4, 1);
        check("alu_alu_stall", {31'd0, stall}, 0);
        step();
        drive(0, 0, 7, 7, 0, 0);
        check("alu_alu_fwd_e0", {30'd0, fwd_e0}, 2);
        check_all("alu_alu");
        flush();

        // lw $5 then sw rt=$5 (tuse 2): store data forwarded from W in M
        drive(0, 0, 7, 7, 5, 2);
        step();
        drive(2, 5, 1, 2, 0, 0);
        check("lw_sw_stall", {31'd0, stall}, 0);
        step();
        drive(0, 0, 7, 7, 0, 0);
        check_all("lw_sw_c2");
        step();
        check("lw_sw_fwd_m1", {31'd0, fwd_m1}, 1);
        check_all("lw_sw_c3");
        flush();

        // lui $7 (tnew 0) then jr $7 (tuse 0)
        drive(0, 0, 7, 7, 7, 0);
        step();
        drive(7, 0, 0, 7, 0, 0);
        check("lui_jr_stall", {31'd0, stall}, 0);
        check("lui_jr_fwd_d0", {30'd0, fwd_d0}, 1);
        flush();

        // E and M both write $9: youngest wins; $0 never forwards
        drive(0, 0, 7, 7, 9, 0);
        step();
        step();
        drive(9, 0, 0, 0, 0, 0);
        check("youngest_fwd_d0", {30'd0, fwd_d0}, 1);
        check("youngest_stall", {31'd0, stall}, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        check("reg0_fwd_d0", {30'd0, fwd_d0}, 0);
        check("reg0_stall", {31'd0, stall}, 0);
        check_all("reg0");
        flush();

        // reset while stalled clears the stall immediately
        drive(0, 0, 7, 7, 6, 3);
        step();
        drive(6, 6, 0, 0, 0, 0);
        check("rst_pre_stall", {31'd0, stall}, 1);
        pulse_reset("rst_mid");
        check("rst_mid_stall", {31'd0, stall}, 0);
        step();
        check("rst_after_stall", {31'd0, stall}, 0);
        check_all("rst_after");

        repeat (400) begin
            if ($urandom_range(0, 49) == 0) pulse_reset("rnd_rst");
            drive($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 4) == 4 ? 7 : $urandom_range(0, 3),
                  $urandom_range(0, 4) == 4 ? 7 : $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
            check_all("rnd");
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
